// File: rtl/mux16_rr_arbiter.sv
// 16-source round-robin arbiter driving a 16:1 bit mux, with bounded bursts
// and one idle arbitration cycle between consecutive grants.
module mux16_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] data_in,
    input  logic        out_ready,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        out_valid,
    output logic        data_out,
    output logic        busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t      state_r;
    logic [3:0]  last_r;
    logic [3:0]  beat_cnt_r;
    logic [15:0] grant_r;
    logic [3:0]  sel_r;
    logic        busy_r;

    logic        any_req_s;
    logic [3:0]  pick_s;
    logic        sel_req_s;
    logic        beat_s;
    logic        burst_done_s;

    // First set bit of r scanning cyclically from start; lowest offset wins.
    function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] start);
        logic [3:0] idx;
        logic [3:0] pick;
        pick = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Arbitration and burst-termination decode.
    always_comb begin
        any_req_s    = 1'b0;
        pick_s       = 4'd0;
        sel_req_s    = 1'b0;
        beat_s       = 1'b0;
        burst_done_s = 1'b0;
        any_req_s    = (req != 16'd0);
        pick_s       = rr_pick(req, last_r + 4'd1);
        sel_req_s    = req[sel_r];
        if (state_r == ST_GRANT) begin
            beat_s       = sel_req_s && out_ready;
            burst_done_s = beat_s && (beat_cnt_r == BURST_LAST);
        end else begin
            beat_s       = 1'b0;
            burst_done_s = 1'b0;
        end
    end

    // Two-state FSM holding grant, select, burst counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            last_r     <= 4'd15;
            beat_cnt_r <= 4'd0;
            grant_r    <= 16'd0;
            sel_r      <= 4'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    beat_cnt_r <= 4'd0;
                    if (any_req_s) begin
                        state_r <= ST_GRANT;
                        grant_r <= 16'd1 << pick_s;
                        sel_r   <= pick_s;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= 16'd0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Exit on dropped request or on the final beat of the burst.
                    if (!sel_req_s || burst_done_s) begin
                        state_r    <= ST_IDLE;
                        last_r     <= sel_r;
                        grant_r    <= 16'd0;
                        beat_cnt_r <= 4'd0;
                        busy_r     <= 1'b0;
                    end else if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + 4'd1;
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= 16'd0;
                    beat_cnt_r <= 4'd0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Beat valid and muxed data; both fall to zero immediately outside a grant.
    always_comb begin
        out_valid = 1'b0;
        data_out  = 1'b0;
        if (state_r == ST_GRANT) begin
            out_valid = sel_req_s;
            data_out  = data_in[sel_r];
        end else begin
            out_valid = 1'b0;
            data_out  = 1'b0;
        end
    end

    assign grant = grant_r;
    assign sel   = sel_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter with MAX_BURST=4.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] data_in;
    logic        out_ready;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        out_valid;
    logic        data_out;
    logic        busy;

    int checks;
    int errors;

    mux16_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 16'd0;
        data_in   = 16'd0;
        out_ready = 1'b0;
        #3;
        checks++;
        if (grant !== 16'd0 || sel !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%h sel=%0d busy=%b valid=%b data=%b, required all 0",
                     grant, sel, busy, out_valid, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 16'h0001;
        #2;
        checks++;
        if (grant !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: grant=%h busy=%b, required 0000/0", grant, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 16'h0001 || sel !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%h sel=%0d busy=%b, required 0001/0/1", grant, sel, busy);
        end
    endtask

    task automatic test_burst_limit();
        do_reset();
        req       = 16'h0020;
        out_ready = 1'b1;
        step();
        checks++;
        if (grant !== 16'h0020 || sel !== 4'd5) begin
            errors++;
            $display("FAIL burst_grant: grant=%h sel=%0d, required 0020/5", grant, sel);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (out_valid !== 1'b1 || grant !== 16'h0020) begin
                errors++;
                $display("FAIL burst_beat%0d: valid=%b grant=%h, required 1/0020", b, out_valid, grant);
            end
            step();
        end
        checks++;
        if (grant !== 16'd0 || busy !== 1'b0 || data_out !== 1'b0 || sel !== 4'd5 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_idle: grant=%h busy=%b data=%b sel=%0d valid=%b, required 0000/0/0/5/0",
                     grant, busy, data_out, sel, out_valid);
        end
        step();
        checks++;
        if (grant !== 16'h0020 || sel !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_regrant: grant=%h sel=%0d busy=%b, required 0020/5/1", grant, sel, busy);
        end
    endtask

    task automatic test_round_robin_datapath();
        logic [3:0]  g;
        logic [15:0] dvec;
        do_reset();
        dvec      = 16'hA5C3;
        data_in   = dvec;
        req       = 16'hFFFF;
        out_ready = 1'b1;
        for (int n = 0; n < 17; n++) begin
            g = 4'(n);
            step();
            checks++;
            if (grant !== (16'd1 << g) || sel !== g) begin
                errors++;
                $display("FAIL rr_grant%0d: grant=%h sel=%0d, required %h/%0d", n, grant, sel, 16'd1 << g, g);
            end
            for (int b = 0; b < 4; b++) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== dvec[g]) begin
                    errors++;
                    $display("FAIL rr_beat%0d_%0d: valid=%b data=%b, required 1/%b", n, b, out_valid, data_out, dvec[g]);
                end
                step();
            end
            checks++;
            if (grant !== 16'd0 || data_out !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle%0d: grant=%h data=%b, required 0000/0", n, grant, data_out);
            end
        end
        // Async reset two beats into a burst on source 1.
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 16'd0 || sel !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: grant=%h sel=%0d busy=%b valid=%b data=%b, required all 0",
                     grant, sel, busy, out_valid, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 16'h0001 || sel !== 4'd0) begin
            errors++;
            $display("FAIL reset_resume: grant=%h sel=%0d, required 0001/0", grant, sel);
        end
    endtask

    task automatic test_skip();
        do_reset();
        req = 16'h0008;
        step();
        req = 16'h0000;
        step();
        checks++;
        if (grant !== 16'd0) begin
            errors++;
            $display("FAIL skip_drop3: grant=%h, required 0000", grant);
        end
        req = 16'h1008;
        step();
        checks++;
        if (grant !== 16'h1000 || sel !== 4'd12) begin
            errors++;
            $display("FAIL skip_grant12: grant=%h sel=%0d, required 1000/12", grant, sel);
        end
        req = 16'h1009;
        step();
        checks++;
        if (grant !== 16'h1000) begin
            errors++;
            $display("FAIL skip_hold12: grant=%h, required 1000", grant);
        end
        req = 16'h0008;
        step();
        step();
        checks++;
        if (grant !== 16'h0008 || sel !== 4'd3) begin
            errors++;
            $display("FAIL skip_grant3: grant=%h sel=%0d, required 0008/3", grant, sel);
        end
    endtask

    task automatic test_stall_drop();
        do_reset();
        req       = 16'h0080;
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (grant !== 16'h0080 || out_valid !== 1'b1 || sel !== 4'd7) begin
                errors++;
                $display("FAIL stall_hold%0d: grant=%h valid=%b sel=%0d, required 0080/1/7", c, grant, out_valid, sel);
            end
        end
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (grant !== 16'h0080) begin
            errors++;
            $display("FAIL stall_count_early: grant=%h, required 0080", grant);
        end
        step();
        checks++;
        if (grant !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_count_exit: grant=%h busy=%b, required 0000/0", grant, busy);
        end
        out_ready = 1'b0;
        step();
        req = 16'h0000;
        step();
        checks++;
        if (grant !== 16'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_exit: grant=%h busy=%b valid=%b, required 0000/0/0", grant, busy, out_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req       = 16'd0;
        data_in   = 16'd0;
        out_ready = 1'b0;
        test_reset();
        test_burst_limit();
        test_round_robin_datapath();
        test_skip();
        test_stall_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
